hmac_queue: RTL and testbench

- Synchronous first-word-fall-through FIFO.
- Each entry is a vector of `elementCount` words, each `elementWidth` bits wide.
- Used by the HMAC/SHA cores as the result queue between the hash pipeline and the serial transmitter:
  - the core pushes result packets;
  - the transmitter reads the head packet byte-by-byte, then pops it.
- Head entry is always visible on `out` with no read latency.

---
 rtl/hmac_queue.sv | 103 ++++++++++
 tb/tb_hmac_queue.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hmac_queue.sv
// hmac_queue - first-word-fall-through result queue between the hash pipeline
// and the serial transmitter. Each entry holds elementCount words of
// elementWidth bits. The head entry is shown on `out` with no read latency.
//
// Parameters:
//   elementWidth - bits per word
//   elementCount - words per entry
//   depth        - number of entries (>= 2)
//
// Ports:
//   clk       - single clock, all state updates on the rising edge
//   reset     - synchronous, active-high; clears pointers and count only
//   write     - push `in` this cycle (accepted if not full, or if popping too)
//   read      - pop the head entry this cycle (ignored when empty)
//   in        - entry to push
//   out       - current head entry, combinational from storage; meaningless
//               while `available` is low
//   available - queue holds at least one entry
//   full      - queue holds depth entries
module hmac_queue #(
  parameter int elementWidth = 32,
  parameter int elementCount = 8,
  parameter int depth        = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write,
  input  logic                    read,
  input  logic [elementWidth-1:0] in  [0:elementCount-1],
  output logic [elementWidth-1:0] out [0:elementCount-1],
  output logic                    available,
  output logic                    full
);

  localparam int PtrW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CntW = $clog2(depth) + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam ptr_t LastPtr  = ptr_t'(depth - 1);
  localparam cnt_t FullCnt  = cnt_t'(depth);

  logic [elementWidth-1:0] mem [0:depth-1][0:elementCount-1];

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  cnt_t count;

  logic push;
  logic pop;

  // Flags come straight from the registered count, so they are stable for the
  // whole cycle.
  assign available = (count != '0);
  assign full      = (count == FullCnt);

  // A read while full frees the head slot in the same edge, so a simultaneous
  // write is accepted and lands in the slot being vacated.
  assign push = write & (~full | read);
  assign pop  = read & available;

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == LastPtr) ? '0 : p + ptr_t'(1);
  endfunction

  // NOTE: storage has no reset; only pointers and count define validity, so
  // clearing the array would cost a reset network for no functional gain.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int w = 0; w < elementCount; w++) begin
        // NOTE: non-blocking assignment for all clocked state so every
        // register samples pre-edge values regardless of statement order.
        mem[wr_ptr][w] <= in[w];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: every output of this block is assigned on every pass, so no latch
  // can be inferred.
  always_comb begin
    for (int w = 0; w < elementCount; w++) begin
      out[w] = mem[rd_ptr][w];
    end
  end

endmodule

// File: tb/tb_hmac_queue.sv
// Self-checking bench for hmac_queue (elementWidth=8, elementCount=4, depth=4).
// A scoreboard queue holds the entries the bench expects the DUT to contain;
// entries are pushed when an accepted write is driven and the head is compared
// against `out` whenever the model is non-empty, and on every pop.
module tb_hmac_queue;

  localparam int EW = 8;
  localparam int EC = 4;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          write;
  logic          read;
  logic [EW-1:0] din  [0:EC-1];
  logic [EW-1:0] dout [0:EC-1];
  logic          available;
  logic          full;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb [$];

  hmac_queue #(.elementWidth(EW), .elementCount(EC), .depth(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .write     (write),
    .read      (read),
    .in        (din),
    .out       (dout),
    .available (available),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] w0, input logic [7:0] w1,
                                     input logic [7:0] w2, input logic [7:0] w3);
    return {w0, w1, w2, w3};
  endfunction

  // Distinct pattern in every word so word-swap or word-drop faults show up.
  function automatic logic [31:0] entry(input logic [7:0] v);
    return mk(v, v ^ 8'h55, v + 8'd100, ~v);
  endfunction

  function automatic logic [31:0] out_packed();
    return {dout[0], dout[1], dout[2], dout[3]};
  endfunction

  task automatic drive_in(input logic [31:0] d);
    din[0] = d[31:24];
    din[1] = d[23:16];
    din[2] = d[15:8];
    din[3] = d[7:0];
  endtask

  // One clock cycle: called just after a falling edge. Checks the current
  // (registered) DUT state against the model, drives the inputs, updates the
  // model for the coming rising edge, then advances to the next falling edge.
  task automatic cycle(input logic wr, input logic rd, input logic [31:0] d);
    logic push_ok;
    logic pop_ok;
    check("available", {31'b0, available}, {31'b0, sb.size() != 0});
    check("full", {31'b0, full}, {31'b0, sb.size() == D});
    if (sb.size() != 0) check("head", out_packed(), sb[0]);
    write = wr;
    read  = rd;
    drive_in(d);
    push_ok = wr && ((sb.size() < D) || rd);
    pop_ok  = rd && (sb.size() > 0);
    if (pop_ok)  void'(sb.pop_front());
    if (push_ok) sb.push_back(d);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset with write and read both asserted to show reset has priority.
  task automatic do_reset();
    reset = 1'b1;
    write = 1'b1;
    read  = 1'b1;
    drive_in(entry(8'hEE));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    write = 1'b0;
    read  = 1'b0;
    sb.delete();
    check("reset_available", {31'b0, available}, 32'd0);
    check("reset_full", {31'b0, full}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    write = 1'b0;
    read  = 1'b0;
    drive_in('0);
    @(negedge clk);
    do_reset();

    // Idle after reset.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);

    // Two pushes, then two pops.
    cycle(1'b1, 1'b0, mk(8'd1, 8'd2, 8'd3, 8'd4));
    check("first_push_available", {31'b0, available}, 32'd1);
    check("first_push_head", out_packed(), mk(8'd1, 8'd2, 8'd3, 8'd4));
    cycle(1'b1, 1'b0, mk(8'd5, 8'd6, 8'd7, 8'd8));
    cycle(1'b0, 1'b1, '0);
    check("second_head", out_packed(), mk(8'd5, 8'd6, 8'd7, 8'd8));
    cycle(1'b0, 1'b1, '0);
    check("drained_available", {31'b0, available}, 32'd0);

    // Fill, drop on full, drain.
    for (int v = 10; v <= 13; v++) cycle(1'b1, 1'b0, entry(8'(v)));
    check("fill_full", {31'b0, full}, 32'd1);
    cycle(1'b1, 1'b0, entry(8'd99));
    check("drop_full", {31'b0, full}, 32'd1);
    for (int v = 10; v <= 13; v++) begin
      check("drain_w0", {24'b0, dout[0]}, 32'(v));
      cycle(1'b0, 1'b1, '0);
    end
    check("after_drain_available", {31'b0, available}, 32'd0);

    // Fill, then simultaneous write and read while full.
    for (int v = 10; v <= 13; v++) cycle(1'b1, 1'b0, entry(8'(v)));
    cycle(1'b1, 1'b1, entry(8'd20));
    check("rw_full_full", {31'b0, full}, 32'd1);
    check("rw_full_head_w0", {24'b0, dout[0]}, 32'd11);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, '0);
    check("rw_full_drained", {31'b0, available}, 32'd0);

    // Pointer wrap-around: push two, pop two, ten rounds.
    for (int r = 0; r < 10; r++) begin
      cycle(1'b1, 1'b0, entry(8'(40 + 2 * r)));
      cycle(1'b1, 1'b0, entry(8'(41 + 2 * r)));
      cycle(1'b0, 1'b1, '0);
      cycle(1'b0, 1'b1, '0);
    end
    cycle(1'b0, 1'b0, '0);

    // Write and read together while empty: push only, no bypass.
    check("pre_rw_empty_available", {31'b0, available}, 32'd0);
    cycle(1'b1, 1'b1, entry(8'd7));
    check("rw_empty_available", {31'b0, available}, 32'd1);
    check("rw_empty_w0", {24'b0, dout[0]}, 32'd7);
    cycle(1'b0, 1'b1, '0);

    // Read on empty queue is ignored.
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);
    check("read_empty_available", {31'b0, available}, 32'd0);

    // Reset with two entries queued.
    cycle(1'b1, 1'b0, entry(8'd50));
    cycle(1'b1, 1'b0, entry(8'd51));
    do_reset();
    cycle(1'b0, 1'b0, '0);

    // Pointers restarted cleanly after reset.
    cycle(1'b1, 1'b0, entry(8'd60));
    check("post_reset_head", out_packed(), entry(8'd60));
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
